// File: rtl/scu_pkg.sv
// Shared types for the trigger response unit: channel FSM states and the
// per-channel configuration record layout.
package scu_pkg;

  localparam int SCU_C      = 8;
  localparam int SCU_HOLD_W = 8;
  localparam int CFG_CH_W   = 2 * SCU_C + SCU_HOLD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STICKY = 2'd2
  } ch_state_e;

  // Field order matches the flat config slice: mask occupies the LSBs.
  typedef struct packed {
    logic [SCU_HOLD_W-1:0] hold;
    logic [SCU_C-1:0]      value;
    logic [SCU_C-1:0]      mask;
  } trigger_response_cfg_t;

endpackage

// File: rtl/trigger_response_channel.sv
// One trigger channel: timed or sticky override state machine with its
// hold down-counter.
module trigger_response_channel
  import scu_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  input  logic              en_i,
  input  logic              cfg_valid_i,
  input  logic              cfg_load_i,
  input  logic              clear_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic              active_o
);

  ch_state_e         state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic hold_zero;
  logic hold_sticky;

  assign hold_zero   = (hold_i == '0);
  assign hold_sticky = &hold_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // A config load or global disable dominates everything, including triggers.
    if (!en_i || cfg_load_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig_i && cfg_valid_i && !hold_zero) begin
            if (hold_sticky) begin
              state_d = ST_STICKY;
            end else begin
              state_d = ST_ACTIVE;
              cnt_d   = hold_i - HOLD_W'(1);
            end
          end
        end
        ST_ACTIVE: begin
          if (trig_i) begin
            cnt_d = hold_i - HOLD_W'(1);
          end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        ST_STICKY: begin
          if (clear_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign active_o = (state_q != ST_IDLE);

endmodule

// File: rtl/trigger_response_unit.sv
// Trigger response unit: holds the channel configuration, runs M override
// channels and merges their overrides onto q_in with low-index priority.
module trigger_response_unit
  import scu_pkg::*;
#(
  parameter int M      = 6,
  parameter int C      = 8,
  parameter int HOLD_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [M-1:0]                trigger,
  input  logic                        ScuEn,
  input  logic [M*(2*C+HOLD_W)-1:0]   CfgIn,
  input  logic                        CfgLoad,
  input  logic [M-1:0]                ClearPatch,
  input  logic [C-1:0]                q_in,
  output logic [C-1:0]                q_out,
  output logic [M-1:0]                PatchActive,
  output logic                        CfgValid
);

  localparam int CH_W = 2 * C + HOLD_W;

  logic [M*CH_W-1:0] cfg_q;
  logic              cfg_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
    end else if (CfgLoad) begin
      cfg_q       <= CfgIn;
      cfg_valid_q <= 1'b1;
    end
  end

  assign CfgValid = cfg_valid_q;

  for (genvar g = 0; g < M; g++) begin : g_ch
    trigger_response_channel #(
      .HOLD_W (HOLD_W)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .trig_i      (trigger[g]),
      .en_i        (ScuEn),
      .cfg_valid_i (cfg_valid_q),
      .cfg_load_i  (CfgLoad),
      .clear_i     (ClearPatch[g]),
      .hold_i      (cfg_q[g*CH_W+2*C +: HOLD_W]),
      .active_o    (PatchActive[g])
    );
  end

  // Apply channels from highest to lowest index so the lowest active one wins.
  always_comb begin
    q_out = q_in;
    for (int m = M - 1; m >= 0; m--) begin
      if (PatchActive[m]) begin
        q_out = (q_out & ~cfg_q[m*CH_W +: C]) | (cfg_q[m*CH_W+C +: C] & cfg_q[m*CH_W +: C]);
      end
    end
  end

endmodule

// File: tb/tb_trigger_response_unit.sv
// Bench for trigger_response_unit: table vectors, directed corner sequences
// and a randomized run against a remaining-cycles reference model.
module tb_trigger_response_unit;

  localparam int M  = 6;
  localparam int C  = 8;
  localparam int HW = 8;
  localparam int CW = 2 * C + HW;

  logic            clk = 1'b0;
  logic            rst;
  logic [M-1:0]    trigger;
  logic            ScuEn;
  logic [M*CW-1:0] CfgIn;
  logic            CfgLoad;
  logic [M-1:0]    ClearPatch;
  logic [C-1:0]    q_in;
  logic [C-1:0]    q_out;
  logic [M-1:0]    PatchActive;
  logic            CfgValid;

  always #5 clk = ~clk;

  trigger_response_unit #(.M(M), .C(C), .HOLD_W(HW)) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .ScuEn       (ScuEn),
    .CfgIn       (CfgIn),
    .CfgLoad     (CfgLoad),
    .ClearPatch  (ClearPatch),
    .q_in        (q_in),
    .q_out       (q_out),
    .PatchActive (PatchActive),
    .CfgValid    (CfgValid)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: per channel, remaining override cycles (0 idle, -1 sticky).
  int              rem [M];
  logic [M*CW-1:0] mcfg;
  bit              mvalid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] chcfg(input logic [7:0] h, input logic [7:0] v, input logic [7:0] mk);
    return {h, v, mk};
  endfunction

  function automatic logic [C-1:0] model_q(input logic [C-1:0] qi);
    logic [C-1:0] r;
    bit found;
    r = qi;
    for (int b = 0; b < C; b++) begin
      found = 0;
      for (int m = 0; m < M; m++) begin
        if (!found && rem[m] != 0 && mcfg[m*CW+b]) begin
          r[b]  = mcfg[m*CW+C+b];
          found = 1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [M-1:0] model_pa();
    logic [M-1:0] p;
    for (int m = 0; m < M; m++) p[m] = (rem[m] != 0);
    return p;
  endfunction

  task automatic model_update(input logic [M-1:0] t, input logic e, input logic [M-1:0] c,
                              input logic ld, input logic r);
    int h;
    if (r) begin
      for (int m = 0; m < M; m++) rem[m] = 0;
      mcfg   = '0;
      mvalid = 0;
    end else begin
      if (ld || !e) begin
        for (int m = 0; m < M; m++) rem[m] = 0;
      end else begin
        for (int m = 0; m < M; m++) begin
          h = int'(mcfg[m*CW+2*C +: HW]);
          if (rem[m] < 0) begin
            if (c[m]) rem[m] = 0;
          end else if (t[m] && mvalid && h != 0) begin
            rem[m] = (h == 255) ? -1 : h;
          end else if (rem[m] > 0) begin
            rem[m]--;
          end
        end
      end
      if (ld) begin
        mcfg   = CfgIn;
        mvalid = 1;
      end
    end
  endtask

  task automatic cyc(input logic [M-1:0] t, input logic e, input logic [M-1:0] c,
                     input logic ld, input logic [C-1:0] qi, input logic r);
    trigger    = t;
    ScuEn      = e;
    ClearPatch = c;
    CfgLoad    = ld;
    q_in       = qi;
    rst        = r;
    @(posedge clk);
    #1;
    model_update(t, e, c, ld, r);
  endtask

  typedef struct {
    logic [M-1:0] trig;
    logic         en;
    logic [C-1:0] qin;
    logic [C-1:0] eq;
    logic [M-1:0] epa;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  task automatic run_table(input string tag, input vec_t tv[$]);
    foreach (tv[i]) begin
      cyc(tv[i].trig, tv[i].en, '0, 1'b0, tv[i].qin, 1'b0);
      chk($sformatf("%s[%0d] q_out", tag, i), 32'(q_out), 32'(tv[i].eq));
      chk($sformatf("%s[%0d] PatchActive", tag, i), 32'(PatchActive), 32'(tv[i].epa));
    end
  endtask

  function automatic logic [7:0] rand_hold();
    case ($urandom_range(0, 6))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h01;
      3: return 8'h02;
      4: return 8'(2 + $urandom_range(0, 6));
      default: return 8'(1 + $urandom_range(0, 20));
    endcase
  endfunction

  task automatic rand_cfg();
    for (int m = 0; m < M; m++) CfgIn[m*CW +: CW] = chcfg(rand_hold(), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    for (int m = 0; m < M; m++) rem[m] = 0;
    mcfg = '0; mvalid = 0;
    rst = 1'b1; trigger = '0; ScuEn = 1'b0; CfgIn = '0; CfgLoad = 1'b0;
    ClearPatch = '0; q_in = 8'hA5;

    // Reset state
    cyc('0, 1'b0, '0, 1'b0, 8'hA5, 1'b1);
    cyc('0, 1'b0, '0, 1'b0, 8'hA5, 1'b1);
    chk("reset q_out", 32'(q_out), 32'h A5);
    chk("reset PatchActive", 32'(PatchActive), 32'h0);
    chk("reset CfgValid", 32'(CfgValid), 32'h0);

    // Triggers before any load are ignored
    cyc(6'h3F, 1'b1, '0, 1'b0, 8'h5A, 1'b0);
    chk("preload PatchActive", 32'(PatchActive), 32'h0);
    chk("preload q_out", 32'(q_out), 32'h5A);

    // Table A: ch0 mask 0F value 05 hold 3; ch1 hold 0 (disabled)
    CfgIn = '0;
    CfgIn[0*CW +: CW] = chcfg(8'd3, 8'h05, 8'h0F);
    CfgIn[1*CW +: CW] = chcfg(8'd0, 8'hFF, 8'hFF);
    cyc('0, 1'b1, '0, 1'b1, 8'hFF, 1'b0);
    chk("load CfgValid", 32'(CfgValid), 32'h1);
    tbl_a.push_back('{6'h00, 1'b1, 8'hFF, 8'hFF, 6'h00});
    tbl_a.push_back('{6'h01, 1'b1, 8'hFF, 8'hF5, 6'h01});
    tbl_a.push_back('{6'h00, 1'b1, 8'hFF, 8'hF5, 6'h01});
    tbl_a.push_back('{6'h00, 1'b1, 8'hFF, 8'hF5, 6'h01});
    tbl_a.push_back('{6'h00, 1'b1, 8'hFF, 8'hFF, 6'h00});
    tbl_a.push_back('{6'h02, 1'b1, 8'hFF, 8'hFF, 6'h00});
    tbl_a.push_back('{6'h01, 1'b0, 8'hFF, 8'hFF, 6'h00});
    run_table("pulse", tbl_a);

    // Table B: ch0 hold 4, retrigger two cycles in -> 6 cycles total
    CfgIn = '0;
    CfgIn[0*CW +: CW] = chcfg(8'd4, 8'hAA, 8'hFF);
    cyc('0, 1'b1, '0, 1'b1, 8'h00, 1'b0);
    tbl_b.push_back('{6'h01, 1'b1, 8'h00, 8'hAA, 6'h01});
    tbl_b.push_back('{6'h00, 1'b1, 8'h00, 8'hAA, 6'h01});
    tbl_b.push_back('{6'h01, 1'b1, 8'h00, 8'hAA, 6'h01});
    tbl_b.push_back('{6'h00, 1'b1, 8'h00, 8'hAA, 6'h01});
    tbl_b.push_back('{6'h00, 1'b1, 8'h00, 8'hAA, 6'h01});
    tbl_b.push_back('{6'h00, 1'b1, 8'h00, 8'hAA, 6'h01});
    tbl_b.push_back('{6'h00, 1'b1, 8'h00, 8'h00, 6'h00});
    run_table("retrig", tbl_b);

    // Overlapping masks: lower index wins per bit
    CfgIn = '0;
    CfgIn[0*CW +: CW] = chcfg(8'd3, 8'h01, 8'h01);
    CfgIn[1*CW +: CW] = chcfg(8'd3, 8'h02, 8'h03);
    cyc('0, 1'b1, '0, 1'b1, 8'h00, 1'b0);
    cyc(6'h03, 1'b1, '0, 1'b0, 8'h00, 1'b0);
    chk("priority q_out", 32'(q_out), 32'h03);
    chk("priority PatchActive", 32'(PatchActive), 32'h03);
    q_in = 8'h80;
    #1;
    chk("comb q_in path", 32'(q_out), 32'h83);

    // Sticky channel 2
    CfgIn = '0;
    CfgIn[0*CW +: CW] = chcfg(8'd10, 8'h00, 8'hFF);
    CfgIn[2*CW +: CW] = chcfg(8'hFF, 8'hAA, 8'hF0);
    cyc('0, 1'b1, '0, 1'b1, 8'h0F, 1'b0);
    cyc(6'h04, 1'b1, '0, 1'b0, 8'h0F, 1'b0);
    chk("sticky enter q_out", 32'(q_out), 32'hAF);
    for (int i = 0; i < 300; i++) cyc('0, 1'b1, '0, 1'b0, 8'h0F, 1'b0);
    chk("sticky 300 PatchActive", 32'(PatchActive), 32'h04);
    chk("sticky 300 q_out", 32'(q_out), 32'hAF);
    cyc('0, 1'b1, 6'h04, 1'b0, 8'h0F, 1'b0);
    chk("sticky clear PatchActive", 32'(PatchActive), 32'h00);
    chk("sticky clear q_out", 32'(q_out), 32'h0F);
    cyc(6'h04, 1'b1, '0, 1'b0, 8'h0F, 1'b0);
    cyc(6'h04, 1'b1, 6'h04, 1'b0, 8'h0F, 1'b0);
    chk("sticky trig+clear", 32'(PatchActive), 32'h00);

    // ScuEn drop during overrides
    cyc(6'h05, 1'b1, '0, 1'b0, 8'h3C, 1'b0);
    chk("en active PatchActive", 32'(PatchActive), 32'h05);
    cyc('0, 1'b0, '0, 1'b0, 8'h3C, 1'b0);
    chk("en drop PatchActive", 32'(PatchActive), 32'h00);
    chk("en drop q_out", 32'(q_out), 32'h3C);
    cyc(6'h01, 1'b0, '0, 1'b0, 8'h3C, 1'b0);
    chk("trig en0 PatchActive", 32'(PatchActive), 32'h00);

    // CfgLoad mid-override, trigger in the same cycle ignored
    cyc(6'h01, 1'b1, '0, 1'b0, 8'h3C, 1'b0);
    chk("pre-load active", 32'(PatchActive), 32'h01);
    cyc(6'h01, 1'b1, '0, 1'b1, 8'h3C, 1'b0);
    chk("cfgload PatchActive", 32'(PatchActive), 32'h00);
    chk("cfgload q_out", 32'(q_out), 32'h3C);

    // Reset mid-override
    cyc(6'h01, 1'b1, '0, 1'b0, 8'h3C, 1'b0);
    cyc('0, 1'b1, '0, 1'b0, 8'h3C, 1'b1);
    chk("rst mid q_out", 32'(q_out), 32'h3C);
    chk("rst mid PatchActive", 32'(PatchActive), 32'h00);
    chk("rst mid CfgValid", 32'(CfgValid), 32'h0);
    cyc(6'h3F, 1'b1, '0, 1'b0, 8'h3C, 1'b0);
    chk("post-rst trig ignored", 32'(PatchActive), 32'h00);

    // Randomized run against the model
    rand_cfg();
    cyc('0, 1'b1, '0, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [M-1:0] t, c;
      logic e, ld, r;
      for (int m = 0; m < M; m++) begin
        t[m] = ($urandom_range(0, 5) == 0);
        c[m] = ($urandom_range(0, 19) == 0);
      end
      e  = ($urandom_range(0, 29) != 0);
      ld = ($urandom_range(0, 99) == 0);
      r  = ($urandom_range(0, 399) == 0);
      if (ld) rand_cfg();
      cyc(t, e, c, ld, 8'($urandom), r);
      chk($sformatf("rand[%0d] q_out", i), 32'(q_out), 32'(model_q(q_in)));
      chk($sformatf("rand[%0d] PatchActive", i), 32'(PatchActive), 32'(model_pa()));
      chk($sformatf("rand[%0d] CfgValid", i), 32'(CfgValid), 32'(mvalid));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trigger_response_unit.md
# trigger_response_unit

Downstream consumer of the signal monitoring unit's M-bit trigger vector. Each trigger channel, when fired, overrides a programmable subset of C controllable SoC signals with programmed values for a programmed number of cycles, or indefinitely until cleared. It sits between the monitoring triggers and the patched host logic, in the same `clk` domain as the monitoring units. Configuration arrives as one flat, already-decrypted vector qualified by a load strobe.

## Interface
Parameters:
- `M`, 6: number of trigger channels; matches the monitoring unit's trigger count.
- `C`, 8: number of controllable signal bits.
- `HOLD_W`, 8: width of the per-channel hold-duration field.

Ports:
- `clk`  in  1: the block's single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `trigger`  in  M: trigger pulses/levels from the monitoring units.
- `ScuEn`  in  1: global enable for override activity.
- `CfgIn`  in  M*(2C+HOLD_W): configuration; channel m occupies slice [m*(2C+HOLD_W) +: 2C+HOLD_W], laid out as {Hold[HOLD_W-1:0], Value[C-1:0], Mask[C-1:0]} with Mask in the LSBs.
- `CfgLoad`  in  1: single-cycle strobe that captures `CfgIn`.
- `ClearPatch`  in  M: per-channel release for sticky channels.
- `q_in`  in  C: original (unpatched) controllable signals.
- `q_out`  out  C: patched controllable signals.
- `PatchActive`  out  M: per-channel override-active flags (registered).
- `CfgValid`  out  1: configuration register holds a loaded configuration.

## Operation
- Configuration register: cleared by reset. Captures `CfgIn` on the cycle `CfgLoad`=1. `CfgValid` rises on the cycle after the first load and stays 1 until reset.
- Per-channel FSM with states IDLE, ACTIVE and STICKY, plus a HOLD_W-bit down-counter `cnt`.
- IDLE -> ACTIVE when `trigger[m]` & `ScuEn` & `CfgValid` & Hold∉{0, all-ones}; `cnt` loads Hold-1.
- IDLE -> STICKY under the same enable conditions when Hold = all-ones.
- Hold = 0: channel disabled; its triggers are ignored.
- ACTIVE: `cnt` decrements each cycle; ACTIVE -> IDLE on the cycle `cnt` is 0.
- Retrigger while in ACTIVE reloads `cnt` to Hold-1 (the override is extended, not stacked).
- STICKY -> IDLE when `ClearPatch[m]`=1. In STICKY, a trigger and `ClearPatch` in the same cycle resolve to clear; the channel is in IDLE next cycle.
- `ScuEn`=0 in any cycle: every channel goes to IDLE next cycle and `cnt` is cleared.
- `CfgLoad`=1: every channel goes to IDLE next cycle, and triggers in that cycle are ignored.
- `PatchActive[m]` = (state != IDLE).
- Output merge (combinational from `q_in` and registered state), per bit b: `q_out[b]` = Value[b] of the lowest-index active channel whose Mask[b]=1; otherwise `q_in[b]`. Lower channel index has priority on overlapping masks.

## Timing
- Reset values: `q_out` = `q_in` (pass-through), `PatchActive`=0, `CfgValid`=0; all channels IDLE with `cnt`=0.
- Trigger-to-override latency: 1 cycle. A trigger sampled at edge t drives `q_out` from edge t onward (after edge t).
- Override duration: exactly Hold cycles after the triggering edge, with no further triggers.
- A continuously asserted trigger holds the override indefinitely (reload every cycle) and releases Hold cycles after the last sampled trigger.
- `ClearPatch` and `ScuEn` deassertion take effect with 1-cycle latency.
- `q_in` -> `q_out` is a zero-latency combinational path.
- Reset mid-override: `q_out` reverts to `q_in` after the reset edge.

## Structure
- Shared package `scu_pkg`: channel state enum (IDLE/ACTIVE/STICKY), the `trigger_response_cfg_t` packed struct {hold, value, mask}, and localparam `CFG_CH_W` = 2C+HOLD_W.
- Sub-module `trigger_response_channel`: one FSM and counter per channel, instantiated M times in a generate loop.
- The top level holds the config register and the priority merge.

## Test plan
- Load cfg with ch0 Mask=0x0F, Value=0x05, Hold=3; `ScuEn`=1, `q_in`=0xFF; pulse `trigger[0]` once -> `q_out`=0xF5 for exactly 3 cycles, then 0xFF; `PatchActive[0]` high for the same 3 cycles.
- ch0 Mask=0x01, Value=0x1; ch1 Mask=0x03, Value=0x2; fire both together with `q_in`=0x00 -> `q_out`=0x03 (bit0 from ch0, bit1 from ch1).
- ch2 Hold=0xFF; trigger once, wait 300 cycles -> still overridden; pulse `ClearPatch[2]` -> `PatchActive[2]`=0 next cycle.
- ch0 Hold=4; retrigger 2 cycles into the override -> override lasts 6 cycles total.
- During an active override, drop `ScuEn` for 1 cycle -> all `PatchActive`=0 next cycle; a trigger with `ScuEn`=0 or Hold=0 -> no override.
- Assert `rst` mid-override and `CfgLoad` mid-override -> `q_out`=`q_in` next cycle; after reset `CfgValid`=0 and triggers are ignored until a load.
